vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares one single-port video RAM between two requesters:
  - the display line prefetcher, which fills a ping-pong line buffer during horizontal blanking;
  - a CPU-side read/write port.
- Sits between the vga timing generator (it consumes sx/sy) and the pixel painter, which reads the line buffer.
- The display fetch has strict priority. The CPU is served only when no fetch is active. A fetch that overruns into the next line's start is flagged.

Parameters:
- CORDW, 11, coordinate width of sx/sy.
- ADDRW, 16, VRAM word address width.
- DATAW, 16, VRAM word width.
- LINE_WORDS, 80, words fetched per scanline (1..2^LBW).
- LBW, 7, line buffer address width.
- LINE_STRIDE, 80, VRAM words between consecutive lines.
- FETCH_X, 640, sx value at which the next line's fetch starts.
- V_RES, 480, visible lines.
- V_TOTAL, 525, total lines per frame.

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix  in  1  asynchronous, active-high reset.
- sx  in  CORDW  horizontal position from vga.
- sy  in  CORDW  vertical position from vga.
- base_addr  in  ADDRW  VRAM address of line 0. Sampled at fetch start.
- cpu_req  in  1  CPU request. Held with its fields stable until accepted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDRW  CPU word address.
- cpu_wdata  in  DATAW  CPU write data.
- cpu_ready  out  1  accept. A transfer occurs when cpu_req && cpu_ready.
- cpu_rvalid  out  1  read data valid pulse.
- cpu_rdata  out  DATAW  read data; equals ram_rdata.
- ram_en  out  1  RAM access this cycle.
- ram_we  out  1  RAM write.
- ram_addr  out  ADDRW  RAM address.
- ram_wdata  out  DATAW  RAM write data.
- ram_rdata  in  DATAW  RAM read data, valid 1 cycle after a read access.
- lb_we  out  1  line buffer write strobe.
- lb_bank  out  1  line buffer bank, equal to the target line's bit 0.
- lb_addr  out  LBW  line buffer word index.
- lb_data  out  DATAW  line buffer data; equals ram_rdata.
- fetch_miss  out  1  one-cycle pulse when a fetch is aborted at line start.
- busy  out  1  high while a fetch is active.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE;
  - cpu_rvalid, lb_we, fetch_miss, busy = 0;
  - word counter = 0, lb_addr = 0, lb_bank = 0.
  - Reset mid-fetch abandons the fetch with no lb_we afterward.
- Target line: tgt = (sy == V_TOTAL-1) ? 0 : sy+1.
- Fetch trigger: sx == FETCH_X && tgt < V_RES. No fetch is triggered for blanking target lines.
- FSM has two states.
  - IDLE:
    - On trigger, latch line_addr = base_addr + tgt*LINE_STRIDE (truncated to ADDRW), clear the word counter and go to FETCH.
    - The trigger cycle issues no RAM access.
    - Otherwise serve the CPU.
  - FETCH:
    - Each cycle issue a read: ram_en=1, ram_we=0, ram_addr = line_addr + cnt.
    - Increment cnt. After cnt == LINE_WORDS-1 is issued, return to IDLE.
- busy = (state == FETCH).
- cpu_ready:
  - Combinational: cpu_req && state == IDLE && !trigger.
  - The trigger wins against a simultaneous CPU request.
- CPU access on accept:
  - ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr, ram_wdata=cpu_wdata, all in the same cycle.
  - A read gives cpu_rvalid=1 in cycle N+1, with cpu_rdata valid in that cycle.
  - A write gives no response.
  - At most one CPU access per cycle; back-to-back accepts are allowed.
- Fetch read data:
  - A read issued in cycle N gives lb_we=1 in cycle N+1, with lb_addr = cnt issued at N and lb_bank = tgt[0].
  - lb_we/lb_addr/lb_bank/cpu_rvalid are registered.
- ram_en=0 in any cycle with no grant. ram_wdata is don't-care when ram_we=0.
- Miss:
  - If state == FETCH when sx == 0, pulse fetch_miss, abort the remaining words and go to IDLE.
  - The in-flight read from the previous cycle still completes its lb_we.
- Single-cycle throughput. A fetch occupies exactly LINE_WORDS cycles after the trigger cycle.
- Address arithmetic wraps modulo 2^ADDRW.

Decomposition:
- Package vdp_pkg:
  - arbiter state enum (IDLE, FETCH);
  - default geometry constants (H/V resolution and totals);
  - LINE_STRIDE/LINE_WORDS defaults.
- Optional sub-module line_fetch_seq: holds the word counter and the address/line-buffer index generation. It is natural but not required; the arbiter keeps the FSM and grant logic.

Test Plan:
- CPU write then read with no fetch pending:
  - write 0xBEEF to 0x0123, then read 0x0123;
  - expect ram_we pulse, then cpu_rvalid one cycle after the read accept with cpu_rdata=0xBEEF.
- Line fetch, sy=9, sx reaches 640, base_addr=0x1000:
  - expect 80 reads at 0x1320..0x136F starting at sx=641;
  - lb_we 1..80 with lb_addr 0..79 and lb_bank=0;
  - busy high for 80 cycles.
- Priority collision: cpu_req held across the fetch trigger:
  - expect cpu_ready=0 from the trigger cycle through the last fetch read;
  - the CPU is accepted in the first IDLE cycle after the fetch.
- Frame wrap:
  - sy=524 → tgt 0, fetch from base_addr, lb_bank=0;
  - sy=479 → tgt 480, no fetch (ram_en stays low at sx=640).
- Miss, with H_TOTAL=700 in the bench and FETCH_X=640:
  - expect fetch_miss pulse at sx=0;
  - exactly 59 lb_we strobes; IDLE afterward.
- Async reset asserted mid-fetch (word 30):
  - expect busy, lb_we and ram_en low immediately;
  - after release, no further lb_we until the next trigger.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared types and default video geometry for the VRAM arbiter slice.
package vdp_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } arb_state_e;

   localparam int DEF_H_RES   = 640;
   localparam int DEF_H_TOTAL = 800;
   localparam int DEF_V_RES   = 480;
   localparam int DEF_V_TOTAL = 525;

   localparam int DEF_CORDW = 11;
   localparam int DEF_ADDRW = 16;
   localparam int DEF_DATAW = 16;
   localparam int DEF_LBW   = 7;

   localparam int DEF_LINE_WORDS  = 80;
   localparam int DEF_LINE_STRIDE = 80;
   // Prefetch begins as soon as the visible part of the current line ends.
   localparam int DEF_FETCH_X     = DEF_H_RES;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of timing, CPU, VRAM and line-buffer signals around the arbiter.
interface vram_arbiter_if #(
   parameter int CORDW = vdp_pkg::DEF_CORDW,
   parameter int ADDRW = vdp_pkg::DEF_ADDRW,
   parameter int DATAW = vdp_pkg::DEF_DATAW,
   parameter int LBW   = vdp_pkg::DEF_LBW
);
   logic [CORDW-1:0] sx;
   logic [CORDW-1:0] sy;
   logic [ADDRW-1:0] base_addr;

   logic             cpu_req;
   logic             cpu_we;
   logic [ADDRW-1:0] cpu_addr;
   logic [DATAW-1:0] cpu_wdata;
   logic             cpu_ready;
   logic             cpu_rvalid;
   logic [DATAW-1:0] cpu_rdata;

   logic             ram_en;
   logic             ram_we;
   logic [ADDRW-1:0] ram_addr;
   logic [DATAW-1:0] ram_wdata;
   logic [DATAW-1:0] ram_rdata;

   logic             lb_we;
   logic             lb_bank;
   logic [LBW-1:0]   lb_addr;
   logic [DATAW-1:0] lb_data;

   logic             fetch_miss;
   logic             busy;

   modport master (
      output sx, sy, base_addr,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_rvalid, cpu_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      output ram_rdata,
      input  lb_we, lb_bank, lb_addr, lb_data,
      input  fetch_miss, busy
   );

   modport slave (
      input  sx, sy, base_addr,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_rvalid, cpu_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      input  ram_rdata,
      output lb_we, lb_bank, lb_addr, lb_data,
      output fetch_miss, busy
   );

endinterface

// File: rtl/vram_arbiter_line_fetch_seq.sv
// Word counter and address / line-buffer index generation for one scanline fetch.
module line_fetch_seq
   import vdp_pkg::*;
#(
   parameter int CORDW       = DEF_CORDW,
   parameter int ADDRW       = DEF_ADDRW,
   parameter int LBW         = DEF_LBW,
   parameter int LINE_STRIDE = DEF_LINE_STRIDE,
   parameter int LINE_WORDS  = DEF_LINE_WORDS
) (
   input  logic             clk_pix,
   input  logic             rst_pix,
   input  logic             start_i,
   input  logic             advance_i,
   input  logic [ADDRW-1:0] base_addr_i,
   input  logic [CORDW-1:0] tgt_i,
   output logic [ADDRW-1:0] fetch_addr_o,
   output logic             last_o,
   output logic             lb_we_o,
   output logic             lb_bank_o,
   output logic [LBW-1:0]   lb_addr_o
);

   logic [ADDRW-1:0] lineAddr_q, lineAddr_d;
   logic [LBW-1:0]   cnt_q, cnt_d;
   logic             bank_q, bank_d;
   logic             lbWe_q;
   logic             lbBank_q;
   logic [LBW-1:0]   lbAddr_q;

   assign fetch_addr_o = lineAddr_q + ADDRW'(cnt_q);
   assign last_o       = (cnt_q == LBW'(LINE_WORDS - 1));

   always_comb begin
      lineAddr_d = lineAddr_q;
      cnt_d      = cnt_q;
      bank_d     = bank_q;
      if (start_i) begin
         lineAddr_d = base_addr_i + ADDRW'(tgt_i) * ADDRW'(LINE_STRIDE);
         cnt_d      = '0;
         bank_d     = tgt_i[0];
      end else if (advance_i) begin
         cnt_d = cnt_q + LBW'(1);
      end
   end

   // Read data returns one cycle after issue, so the strobe and index trail the counter.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         lineAddr_q <= '0;
         cnt_q      <= '0;
         bank_q     <= 1'b0;
         lbWe_q     <= 1'b0;
         lbBank_q   <= 1'b0;
         lbAddr_q   <= '0;
      end else begin
         lineAddr_q <= lineAddr_d;
         cnt_q      <= cnt_d;
         bank_q     <= bank_d;
         lbWe_q     <= advance_i;
         if (advance_i) begin
            lbAddr_q <= cnt_q;
            lbBank_q <= bank_q;
         end
      end
   end

   assign lb_we_o   = lbWe_q;
   assign lb_bank_o = lbBank_q;
   assign lb_addr_o = lbAddr_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display line prefetch has strict priority over the CPU port.
module vram_arbiter
   import vdp_pkg::*;
#(
   parameter int CORDW       = DEF_CORDW,
   parameter int ADDRW       = DEF_ADDRW,
   parameter int DATAW       = DEF_DATAW,
   parameter int LINE_WORDS  = DEF_LINE_WORDS,
   parameter int LBW         = DEF_LBW,
   parameter int LINE_STRIDE = DEF_LINE_STRIDE,
   parameter int FETCH_X     = DEF_FETCH_X,
   parameter int V_RES       = DEF_V_RES,
   parameter int V_TOTAL     = DEF_V_TOTAL
) (
   input  logic           clk_pix,
   input  logic           rst_pix,
   vram_arbiter_if.slave  bus
);

   arb_state_e       state_q, state_d;
   logic [CORDW-1:0] tgt;
   logic             trigger;
   logic             start;
   logic             advance;
   logic             last;
   logic             cpuAccept;
   logic             cpuRvalid_q;
   logic [ADDRW-1:0] fetchAddr;

   assign tgt     = (bus.sy == CORDW'(V_TOTAL - 1)) ? '0 : bus.sy + CORDW'(1);
   assign trigger = (bus.sx == CORDW'(FETCH_X)) && (tgt < CORDW'(V_RES));

   line_fetch_seq #(
      .CORDW       (CORDW),
      .ADDRW       (ADDRW),
      .LBW         (LBW),
      .LINE_STRIDE (LINE_STRIDE),
      .LINE_WORDS  (LINE_WORDS)
   ) u_seq (
      .clk_pix      (clk_pix),
      .rst_pix      (rst_pix),
      .start_i      (start),
      .advance_i    (advance),
      .base_addr_i  (bus.base_addr),
      .tgt_i        (tgt),
      .fetch_addr_o (fetchAddr),
      .last_o       (last),
      .lb_we_o      (bus.lb_we),
      .lb_bank_o    (bus.lb_bank),
      .lb_addr_o    (bus.lb_addr)
   );

   // Trigger cycle only latches the line; the CPU is locked out from there to the last read.
   always_comb begin
      state_d        = state_q;
      start          = 1'b0;
      advance        = 1'b0;
      cpuAccept      = 1'b0;
      bus.fetch_miss = 1'b0;
      bus.ram_en     = 1'b0;
      bus.ram_we     = 1'b0;
      bus.ram_addr   = '0;
      bus.ram_wdata  = '0;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               start   = 1'b1;
               state_d = FETCH;
            end else if (bus.cpu_req) begin
               cpuAccept     = 1'b1;
               bus.ram_en    = 1'b1;
               bus.ram_we    = bus.cpu_we;
               bus.ram_addr  = bus.cpu_addr;
               bus.ram_wdata = bus.cpu_wdata;
            end
         end
         FETCH: begin
            if (bus.sx == '0) begin
               bus.fetch_miss = 1'b1;
               state_d        = IDLE;
            end else begin
               advance      = 1'b1;
               bus.ram_en   = 1'b1;
               bus.ram_addr = fetchAddr;
               if (last) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         state_q     <= IDLE;
         cpuRvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cpuRvalid_q <= cpuAccept && !bus.cpu_we;
      end
   end

   assign bus.cpu_ready  = cpuAccept;
   assign bus.cpu_rvalid = cpuRvalid_q;
   assign bus.cpu_rdata  = bus.ram_rdata;
   assign bus.lb_data    = bus.ram_rdata;
   assign bus.busy       = (state_q == FETCH);

endmodule
